// File: rtl/y86_seq_controller.sv
// SEQ Y86-64 phase sequencer: owns PC, condition codes and Stat; steps the stages one-hot.
// Define Y86_PERF_COUNT_EN to add cycle_count / instr_count performance counters.
module y86_seq_controller #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        imem_error,
    input  logic        instr_valid,
    input  logic        dmem_ready,
    input  logic        dmem_error,
    input  logic        alu_zf,
    input  logic        alu_of,
    input  logic        alu_sf,
    input  logic [63:0] pc_next,
    output logic [63:0] pc,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        pcupd_en,
    output logic        cc_zf,
    output logic        cc_of,
    output logic        cc_sf,
    output logic [2:0]  stat,
    output logic        halted
`ifdef Y86_PERF_COUNT_EN
    ,
    output logic [63:0] cycle_count,
    output logic [63:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StPcupd, StStop
    } state_e;

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;
    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [2:0]  cc_q, cc_d;  // {zf, of, sf}
    logic [2:0]  stat_q, stat_d;
    logic [3:0]  icode_q, icode_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  wait_inc;
    logic        mem_icode;

    assign wait_inc = wait_q + 8'd1;

    always_comb begin
        unique case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_icode = 1'b1;
            default:                            mem_icode = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cc_d      = cc_q;
        stat_d    = stat_q;
        icode_d   = icode_q;
        wait_d    = wait_q;
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        pcupd_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                fetch_en = 1'b1;
                icode_d  = icode;
                if (imem_error) begin
                    stat_d  = StatAdr;
                    state_d = StStop;
                end else if (!instr_valid) begin
                    stat_d  = StatIns;
                    state_d = StStop;
                end else if (icode == 4'h0) begin
                    stat_d  = StatHlt;
                    state_d = StStop;
                end else begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                decode_en = 1'b1;
                state_d   = StExec;
            end
            StExec: begin
                exec_en = 1'b1;
                if (icode_q == 4'h6) cc_d = {alu_zf, alu_of, alu_sf};
                wait_d  = 8'd0;
                state_d = StMem;
            end
            StMem: begin
                mem_en = 1'b1;
                if (!mem_icode) begin
                    state_d = StWb;
                end else if (dmem_ready) begin
                    if (dmem_error) begin
                        stat_d  = StatAdr;
                        state_d = StStop;
                    end else begin
                        state_d = StWb;
                    end
                end else begin
                    wait_d = wait_inc;
                    // Current cycle is the wait_inc-th consecutive not-ready cycle.
                    if (wait_inc == TimeoutCnt) begin
                        stat_d  = StatAdr;
                        state_d = StStop;
                    end
                end
            end
            StWb: begin
                wb_en   = 1'b1;
                state_d = StPcupd;
            end
            StPcupd: begin
                pcupd_en = 1'b1;
                pc_d     = pc_next;
                state_d  = StFetch;
            end
            StStop: begin
                state_d = StStop;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            cc_q    <= 3'b000;
            stat_q  <= StatAok;
            icode_q <= 4'h0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cc_q    <= cc_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            wait_q  <= wait_d;
        end
    end

    assign pc     = pc_q;
    assign cc_zf  = cc_q[2];
    assign cc_of  = cc_q[1];
    assign cc_sf  = cc_q[0];
    assign stat   = stat_q;
    assign halted = (stat_q != StatAok);

`ifdef Y86_PERF_COUNT_EN
    logic [63:0] cycle_q, instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= 64'd0;
            instr_q <= 64'd0;
        end else begin
            if (state_q != StIdle && state_q != StStop) cycle_q <= cycle_q + 64'd1;
            if (state_q == StPcupd) instr_q <= instr_q + 64'd1;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`endif

endmodule

// File: tb/tb_y86_seq_controller.sv
// Scoreboard bench for y86_seq_controller: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_y86_seq_controller;

    localparam logic [5:0] E0 = 6'b000000;
    localparam logic [5:0] EF = 6'b100000;
    localparam logic [5:0] ED = 6'b010000;
    localparam logic [5:0] EE = 6'b001000;
    localparam logic [5:0] EM = 6'b000100;
    localparam logic [5:0] EW = 6'b000010;
    localparam logic [5:0] EP = 6'b000001;

    logic        clk, rst, start;
    logic [3:0]  icode;
    logic        imem_error, instr_valid, dmem_ready, dmem_error;
    logic        alu_zf, alu_of, alu_sf;
    logic [63:0] pc_next, pc;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pcupd_en;
    logic        cc_zf, cc_of, cc_sf, halted;
    logic [2:0]  stat;
`ifdef Y86_PERF_COUNT_EN
    logic [63:0] cycle_count, instr_count;
`endif

    y86_seq_controller #(
        .RESET_PC   (64'h100),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .icode      (icode),
        .imem_error (imem_error),
        .instr_valid(instr_valid),
        .dmem_ready (dmem_ready),
        .dmem_error (dmem_error),
        .alu_zf     (alu_zf),
        .alu_of     (alu_of),
        .alu_sf     (alu_sf),
        .pc_next    (pc_next),
        .pc         (pc),
        .fetch_en   (fetch_en),
        .decode_en  (decode_en),
        .exec_en    (exec_en),
        .mem_en     (mem_en),
        .wb_en      (wb_en),
        .pcupd_en   (pcupd_en),
        .cc_zf      (cc_zf),
        .cc_of      (cc_of),
        .cc_sf      (cc_sf),
        .stat       (stat),
        .halted     (halted)
`ifdef Y86_PERF_COUNT_EN
        ,
        .cycle_count(cycle_count),
        .instr_count(instr_count)
`endif
    );

    typedef struct {
        string       nm;
        logic [5:0]  en;
        logic [63:0] pc;
        logic [2:0]  cc;
        logic [2:0]  st;
        bit          pchk;
        logic [63:0] icnt;
        logic [63:0] ccnt;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          perf_chk = 0;
    logic [63:0] perf_icnt = 0;
    logic [63:0] perf_ccnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t       e;
            logic [5:0] act_en;
            e      = exp_q.pop_front();
            act_en = {fetch_en, decode_en, exec_en, mem_en, wb_en, pcupd_en};
            total++;
            if (act_en !== e.en || pc !== e.pc || {cc_zf, cc_of, cc_sf} !== e.cc ||
                stat !== e.st || halted !== (e.st != 3'd1)) begin
                bad++;
                $display("FAIL %s: en=%b pc=%h cc=%b stat=%0d halted=%b, want en=%b pc=%h cc=%b stat=%0d",
                         e.nm, act_en, pc, {cc_zf, cc_of, cc_sf}, stat, halted,
                         e.en, e.pc, e.cc, e.st);
            end
`ifdef Y86_PERF_COUNT_EN
            if (e.pchk) begin
                total++;
                if (instr_count !== e.icnt || cycle_count !== e.ccnt) begin
                    bad++;
                    $display("FAIL %s_perf: instr=%0d cycle=%0d, want instr=%0d cycle=%0d",
                             e.nm, instr_count, cycle_count, e.icnt, e.ccnt);
                end
            end
`endif
        end
    end

    // Queue the outputs expected during the current cycle, then advance one clock.
    task automatic tick(input string nm, input logic [5:0] en, input logic [63:0] p,
                        input logic [2:0] cc, input logic [2:0] st);
        exp_t e;
        e.nm   = nm;
        e.en   = en;
        e.pc   = p;
        e.cc   = cc;
        e.st   = st;
        e.pchk = perf_chk;
        e.icnt = perf_icnt;
        e.ccnt = perf_ccnt;
        perf_chk = 0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_tick(input string nm, input logic [5:0] en, input logic [63:0] p,
                            input logic [2:0] cc, input logic [2:0] st);
        rst = 1'b1;
        tick(nm, en, p, cc, st);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; icode = 4'h0; imem_error = 1'b0; instr_valid = 1'b1;
        dmem_ready = 1'b0; dmem_error = 1'b0; alu_zf = 1'b0; alu_of = 1'b0; alu_sf = 1'b0;
        pc_next = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Non-memory icode 2; later icode changes must not matter (latched copy used).
        start = 1'b1;
        tick("reset_idle", E0, 64'h100, 3'b000, 3'd1);
        start = 1'b0; icode = 4'h2;
        tick("i1_fetch", EF, 64'h100, 3'b000, 3'd1);
        icode = 4'h5; alu_zf = 1'b1; alu_of = 1'b1; alu_sf = 1'b1;
        tick("i1_decode", ED, 64'h100, 3'b000, 3'd1);
        tick("i1_exec", EE, 64'h100, 3'b000, 3'd1);
        tick("i1_mem", EM, 64'h100, 3'b000, 3'd1);
        tick("i1_wb", EW, 64'h100, 3'b000, 3'd1);
        pc_next = 64'h102;
        tick("i1_pcupd", EP, 64'h100, 3'b000, 3'd1);

        // OPq loads CC from ALU flags.
        icode = 4'h6;
        tick("i2_fetch", EF, 64'h102, 3'b000, 3'd1);
        icode = 4'h0; alu_zf = 1'b1; alu_of = 1'b1; alu_sf = 1'b0;
        tick("i2_decode", ED, 64'h102, 3'b000, 3'd1);
        tick("i2_exec", EE, 64'h102, 3'b000, 3'd1);
        alu_zf = 1'b0; alu_of = 1'b0; alu_sf = 1'b0;
        tick("i2_mem_cc", EM, 64'h102, 3'b110, 3'd1);
        tick("i2_wb", EW, 64'h102, 3'b110, 3'd1);
        pc_next = 64'h10c;
        tick("i2_pcupd", EP, 64'h102, 3'b110, 3'd1);

        // icode 2 with different flags: CC holds.
        icode = 4'h2;
        tick("i3_fetch", EF, 64'h10c, 3'b110, 3'd1);
        alu_zf = 1'b0; alu_of = 1'b0; alu_sf = 1'b1;
        tick("i3_decode", ED, 64'h10c, 3'b110, 3'd1);
        tick("i3_exec", EE, 64'h10c, 3'b110, 3'd1);
        tick("i3_mem_cc_hold", EM, 64'h10c, 3'b110, 3'd1);
        tick("i3_wb", EW, 64'h10c, 3'b110, 3'd1);
        pc_next = 64'h10e;
        tick("i3_pcupd", EP, 64'h10c, 3'b110, 3'd1);

        // mrmovq with 3 wait cycles: MEM lasts 4 cycles.
        icode = 4'h5;
        perf_chk = 1; perf_icnt = 64'd3; perf_ccnt = 64'd18;
        tick("i4_fetch", EF, 64'h10e, 3'b110, 3'd1);
        icode = 4'h2;
        tick("i4_decode", ED, 64'h10e, 3'b110, 3'd1);
        tick("i4_exec", EE, 64'h10e, 3'b110, 3'd1);
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick("i4_mem_wait", EM, 64'h10e, 3'b110, 3'd1);
        dmem_ready = 1'b1;
        tick("i4_mem_ready", EM, 64'h10e, 3'b110, 3'd1);
        dmem_ready = 1'b0;
        tick("i4_wb", EW, 64'h10e, 3'b110, 3'd1);
        pc_next = 64'h118;
        tick("i4_pcupd", EP, 64'h10e, 3'b110, 3'd1);

        // rmmovq with dmem_error -> ADR, PC unchanged, start ignored in STOP.
        icode = 4'h4;
        tick("i5_fetch", EF, 64'h118, 3'b110, 3'd1);
        tick("i5_decode", ED, 64'h118, 3'b110, 3'd1);
        tick("i5_exec", EE, 64'h118, 3'b110, 3'd1);
        dmem_ready = 1'b1; dmem_error = 1'b1;
        tick("i5_mem_err", EM, 64'h118, 3'b110, 3'd1);
        dmem_ready = 1'b0; dmem_error = 1'b0; start = 1'b1;
        tick("dmem_err_stop", E0, 64'h118, 3'b110, 3'd3);
        tick("dmem_err_stop_hold", E0, 64'h118, 3'b110, 3'd3);
        start = 1'b0;
        rst_tick("rst_from_stop", E0, 64'h118, 3'b110, 3'd3);

        // Timeout with MEM_TIMEOUT=4.
        start = 1'b1;
        perf_chk = 1; perf_icnt = 64'd0; perf_ccnt = 64'd0;
        tick("idle_after_rst", E0, 64'h100, 3'b000, 3'd1);
        start = 1'b0; icode = 4'hA;
        tick("to_fetch", EF, 64'h100, 3'b000, 3'd1);
        icode = 4'h0;
        tick("to_decode", ED, 64'h100, 3'b000, 3'd1);
        tick("to_exec", EE, 64'h100, 3'b000, 3'd1);
        for (int i = 0; i < 4; i++) tick("to_mem_wait", EM, 64'h100, 3'b000, 3'd1);
        start = 1'b1;
        tick("timeout_stop", E0, 64'h100, 3'b000, 3'd3);
        tick("timeout_start_ignored", E0, 64'h100, 3'b000, 3'd3);
        start = 1'b0;
        rst_tick("rst_after_timeout", E0, 64'h100, 3'b000, 3'd3);

        // Fetch error priority: ADR > INS > HLT.
        start = 1'b1;
        tick("idle_fe1", E0, 64'h100, 3'b000, 3'd1);
        start = 1'b0; imem_error = 1'b1; instr_valid = 1'b0; icode = 4'h0;
        tick("fe1_fetch", EF, 64'h100, 3'b000, 3'd1);
        imem_error = 1'b0;
        tick("fe_adr_stop", E0, 64'h100, 3'b000, 3'd3);
        rst_tick("rst_fe1", E0, 64'h100, 3'b000, 3'd3);
        start = 1'b1;
        tick("idle_fe2", E0, 64'h100, 3'b000, 3'd1);
        start = 1'b0; instr_valid = 1'b0;
        tick("fe2_fetch", EF, 64'h100, 3'b000, 3'd1);
        instr_valid = 1'b1;
        tick("fe_ins_stop", E0, 64'h100, 3'b000, 3'd4);
        rst_tick("rst_fe2", E0, 64'h100, 3'b000, 3'd4);
        start = 1'b1;
        tick("idle_fe3", E0, 64'h100, 3'b000, 3'd1);
        start = 1'b0;
        tick("fe3_fetch", EF, 64'h100, 3'b000, 3'd1);
        tick("fe_hlt_stop", E0, 64'h100, 3'b000, 3'd2);
        rst_tick("rst_fe3", E0, 64'h100, 3'b000, 3'd2);

        // Reset during MEM wait clears PC and CC.
        start = 1'b1;
        tick("idle_rm", E0, 64'h100, 3'b000, 3'd1);
        start = 1'b0; icode = 4'h6;
        tick("rm_op_fetch", EF, 64'h100, 3'b000, 3'd1);
        tick("rm_op_decode", ED, 64'h100, 3'b000, 3'd1);
        alu_zf = 1'b1; alu_of = 1'b1; alu_sf = 1'b1;
        tick("rm_op_exec", EE, 64'h100, 3'b000, 3'd1);
        tick("rm_op_mem", EM, 64'h100, 3'b111, 3'd1);
        tick("rm_op_wb", EW, 64'h100, 3'b111, 3'd1);
        pc_next = 64'h200;
        tick("rm_op_pcupd", EP, 64'h100, 3'b111, 3'd1);
        icode = 4'h8;
        tick("rm_call_fetch", EF, 64'h200, 3'b111, 3'd1);
        tick("rm_call_decode", ED, 64'h200, 3'b111, 3'd1);
        tick("rm_call_exec", EE, 64'h200, 3'b111, 3'd1);
        dmem_ready = 1'b0;
        tick("rm_call_mem_wait", EM, 64'h200, 3'b111, 3'd1);
        rst_tick("rm_rst_in_mem", EM, 64'h200, 3'b111, 3'd1);
        tick("rm_idle_after_rst", E0, 64'h100, 3'b000, 3'd1);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d, want pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
